// File: rtl/isa_pkg.sv
// Instruction-set constants shared by the encoder and the control unit:
// kind codes, category bits, ALU opcodes, field positions and loader states.
package isa_pkg;

  localparam logic [1:0] KIND_DP  = 2'b00;
  localparam logic [1:0] KIND_LS  = 2'b01;
  localparam logic [1:0] KIND_BR  = 2'b10;
  localparam logic [1:0] KIND_ILL = 2'b11;

  localparam logic [1:0] CAT_DP = 2'b00;
  localparam logic [1:0] CAT_LS = 2'b01;
  localparam logic [2:0] CAT_BR = 3'b101;

  localparam logic [3:0] OP_ADD         = 4'b0000;
  localparam logic [3:0] OP_SUB         = 4'b0001;
  localparam logic [3:0] OP_RSB         = 4'b0010;
  localparam logic [3:0] OP_ADC         = 4'b0011;
  localparam logic [3:0] OP_SBC         = 4'b0100;
  localparam logic [3:0] OP_AND         = 4'b0101;
  localparam logic [3:0] OP_OR          = 4'b0110;
  localparam logic [3:0] OP_XOR         = 4'b0111;
  localparam logic [3:0] OP_NOT_A       = 4'b1000;
  localparam logic [3:0] OP_PASS_B      = 4'b1001;
  localparam logic [3:0] OP_LSL         = 4'b1010;
  localparam logic [3:0] OP_LSR         = 4'b1011;
  localparam logic [3:0] OP_A_AND_NOT_B = 4'b1100;
  localparam logic [3:0] OP_MAX         = 4'b1100;

  localparam int unsigned COND_LSB   = 28;
  localparam int unsigned CAT_LSB    = 26;
  localparam int unsigned BR_CAT_LSB = 25;
  localparam int unsigned I_BIT      = 25;
  localparam int unsigned P_BIT      = 24;
  localparam int unsigned LINK_BIT   = 24;
  localparam int unsigned U_BIT      = 23;
  localparam int unsigned B_BIT      = 22;
  localparam int unsigned W_BIT      = 21;
  localparam int unsigned OPC_LSB    = 21;
  localparam int unsigned S_BIT      = 20;
  localparam int unsigned RN_LSB     = 16;
  localparam int unsigned RD_LSB     = 12;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WB0  = 3'd1,
    ST_WB1  = 3'd2,
    ST_WB2  = 3'd3,
    ST_WB3  = 3'd4
  } wr_state_e;

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: decoded instruction fields to the 32-bit word,
// flagging records the decoder could never have produced.
module instr_pack
  import isa_pkg::*;
(
  input  logic [1:0]  kind_i,
  input  logic [3:0]  cond_i,
  input  logic        i_i,
  input  logic [3:0]  opcode_i,
  input  logic        s_i,
  input  logic        p_i,
  input  logic        u_i,
  input  logic        b_i,
  input  logic        w_i,
  input  logic        link_i,
  input  logic [3:0]  rn_i,
  input  logic [3:0]  rd_i,
  input  logic [23:0] imm_i,
  output logic [31:0] word_o,
  output logic        illegal_o
);

  always_comb begin
    word_o                   = '0;
    illegal_o                = 1'b0;
    word_o[COND_LSB +: 4]    = cond_i;
    case (kind_i)
      KIND_DP: begin
        word_o[CAT_LSB +: 2] = CAT_DP;
        word_o[I_BIT]        = i_i;
        word_o[OPC_LSB +: 4] = opcode_i;
        word_o[S_BIT]        = s_i;
        word_o[RN_LSB +: 4]  = rn_i;
        word_o[RD_LSB +: 4]  = rd_i;
        word_o[11:0]         = imm_i[11:0];
        illegal_o            = (opcode_i > OP_MAX);
      end
      KIND_LS: begin
        word_o[CAT_LSB +: 2] = CAT_LS;
        word_o[I_BIT]        = i_i;
        word_o[P_BIT]        = p_i;
        word_o[U_BIT]        = u_i;
        word_o[B_BIT]        = b_i;
        word_o[W_BIT]        = w_i;
        word_o[S_BIT]        = s_i;
        word_o[RN_LSB +: 4]  = rn_i;
        word_o[RD_LSB +: 4]  = rd_i;
        word_o[11:0]         = imm_i[11:0];
      end
      KIND_BR: begin
        word_o[BR_CAT_LSB +: 3] = CAT_BR;
        word_o[LINK_BIT]        = link_i;
        word_o[23:0]            = imm_i;
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_word_encoder.sv
// Program loader: accepts field records, packs them into instruction words and
// streams each word big-endian into byte-wide memory at an incrementing address.
module instr_word_encoder
  import isa_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0,
  parameter int MAX_WORDS = 64
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clear,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [1:0]                       in_kind,
  input  logic [3:0]                       in_cond,
  input  logic                             in_i,
  input  logic [3:0]                       in_opcode,
  input  logic                             in_s,
  input  logic                             in_p,
  input  logic                             in_u,
  input  logic                             in_b,
  input  logic                             in_w,
  input  logic                             in_link,
  input  logic [3:0]                       in_rn,
  input  logic [3:0]                       in_rd,
  input  logic [23:0]                      in_imm,
  output logic                             mem_we,
  output logic [ADDR_W-1:0]                mem_addr,
  output logic [7:0]                       mem_wdata,
  output logic [31:0]                      word_out,
  output logic [$clog2(MAX_WORDS+1)-1:0]   word_count,
  output logic                             full,
  output logic                             err
);

  localparam int CNT_W = $clog2(MAX_WORDS + 1);

  wr_state_e         state_q, state_d;
  logic [31:0]       word_q, word_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;

  logic [31:0]       packed_word;
  logic              illegal;
  logic              accept;
  logic [ADDR_W-1:0] word_base;

  instr_pack u_pack (
    .kind_i    (in_kind),
    .cond_i    (in_cond),
    .i_i       (in_i),
    .opcode_i  (in_opcode),
    .s_i       (in_s),
    .p_i       (in_p),
    .u_i       (in_u),
    .b_i       (in_b),
    .w_i       (in_w),
    .link_i    (in_link),
    .rn_i      (in_rn),
    .rd_i      (in_rd),
    .imm_i     (in_imm),
    .word_o    (packed_word),
    .illegal_o (illegal)
  );

  assign full      = (cnt_q == CNT_W'(MAX_WORDS));
  assign in_ready  = (state_q == ST_IDLE) & ~full & ~clear & rst_n;
  assign accept    = in_valid & in_ready;
  assign word_base = ADDR_W'(BASE_ADDR) + ADDR_W'({cnt_q, 2'b00});

  // Memory port outputs are registered from the next state, so each WBk
  // cycle already presents its own address and byte.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        we_d = 1'b0;
        if (clear) begin
          cnt_d = '0;
          err_d = 1'b0;
        end else if (accept) begin
          if (illegal) begin
            err_d = 1'b1;
          end else begin
            word_d  = packed_word;
            state_d = ST_WB0;
            we_d    = 1'b1;
            addr_d  = word_base;
            wdata_d = packed_word[31:24];
          end
        end
      end
      ST_WB0: begin
        state_d = ST_WB1;
        addr_d  = addr_q + ADDR_W'(1);
        wdata_d = word_q[23:16];
      end
      ST_WB1: begin
        state_d = ST_WB2;
        addr_d  = addr_q + ADDR_W'(1);
        wdata_d = word_q[15:8];
      end
      ST_WB2: begin
        state_d = ST_WB3;
        addr_d  = addr_q + ADDR_W'(1);
        wdata_d = word_q[7:0];
      end
      ST_WB3: begin
        state_d = ST_IDLE;
        we_d    = 1'b0;
        cnt_d   = cnt_q + CNT_W'(1);
      end
      default: begin
        state_d = ST_IDLE;
        we_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign word_out   = word_q;
  assign word_count = cnt_q;
  assign err        = err_q;

endmodule
